// File: rtl/jk_excite_ctrl.sv
// Drives a bank of external JK flops to a target word using inverse
// JK excitation from the bank's current Q, with verify and bounded retry.
module jk_excite_ctrl #(
   parameter int WIDTH     = 4,
   parameter int MAX_RETRY = 2,
   parameter int FILL_MODE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tgt_valid,
   output logic             tgt_ready,
   input  logic [WIDTH-1:0] tgt_data,
   input  logic [WIDTH-1:0] q_in,
   output logic [WIDTH-1:0] j_out,
   output logic [WIDTH-1:0] k_out,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   typedef enum logic [1:0] {
      IDLE,
      APPLY,
      CHECK
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] tgt;
   logic [RW-1:0]    retry_cnt;
   logic [WIDTH-1:0] ex_t;
   logic [WIDTH-1:0] ex_j;
   logic [WIDTH-1:0] ex_k;

   // In IDLE the excitation targets the incoming word, otherwise the latched one
   always_comb begin
      ex_t = (state == IDLE) ? tgt_data : tgt;
      ex_j = '0;
      ex_k = '0;
      if (FILL_MODE != 0) begin
         ex_j = q_in ^ ex_t;
         ex_k = q_in ^ ex_t;
      end else begin
         ex_j = ~q_in & ex_t;
         ex_k = q_in & ~ex_t;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         tgt       <= '0;
         retry_cnt <= '0;
         j_out     <= '0;
         k_out     <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         unique case (state)
            IDLE: begin
               j_out <= '0;
               k_out <= '0;
               if (tgt_valid) begin
                  tgt       <= tgt_data;
                  j_out     <= ex_j;
                  k_out     <= ex_k;
                  retry_cnt <= '0;
                  state     <= APPLY;
               end
            end
            APPLY: begin
               j_out <= '0;
               k_out <= '0;
               state <= CHECK;
            end
            CHECK: begin
               if (q_in == tgt) begin
                  done  <= 1'b1;
                  state <= IDLE;
               end else if (retry_cnt < RW'(MAX_RETRY)) begin
                  j_out     <= ex_j;
                  k_out     <= ex_k;
                  retry_cnt <= retry_cnt + RW'(1);
                  state     <= APPLY;
               end else begin
                  err   <= 1'b1;
                  state <= IDLE;
               end
            end
            default: begin
               j_out <= '0;
               k_out <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign tgt_ready = (state == IDLE) && !rst;
   assign busy      = (state != IDLE);

endmodule
